// File: rtl/typedefs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : typedefs_pkg
//  Description : Shared widths, item type and difficulty-to-length table for
//                the Genius sequence datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package typedefs_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int ADDR_WIDTH = 5;

  // One bit per button/LED; a colour item is always one-hot.
  typedef logic [DATA_WIDTH-1:0] item_t;

  // Target sequence length for each difficulty setting.
  localparam int DIFF_LEN_0 = 8;
  localparam int DIFF_LEN_1 = 16;
  localparam int DIFF_LEN_2 = 24;
  localparam int DIFF_LEN_3 = 31;

endpackage
`default_nettype wire

// File: rtl/sequence_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_lfsr
//  Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing a one-hot
//                colour item from its two low state bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_lfsr
  import typedefs_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic  clk,
  input  logic  rst,
  output item_t item
);

  logic [7:0] r_lfsr;
  logic       w_feedback;

  assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Free-running shift; an all-zero state would lock up, so it reloads the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_lfsr == 8'h00) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_feedback};
    end
  end

  assign item = item_t'(1) << r_lfsr[1:0];

endmodule
`default_nettype wire

// File: rtl/sequence_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_datapath
//  Description : Datapath responder to the Genius controller FSM. Executes
//                single-cycle command strobes: settings latch, random item
//                generation, sequence memory, index counters, LEDs and score.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_datapath #(
  parameter int         DATA_WIDTH      = 4,
  parameter int         DIFICULTY_WIDTH = 2,
  parameter int         ADDR_WIDTH      = 5,
  parameter int         SCORE_WIDTH     = 8,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      player_input,
  input  logic [DIFICULTY_WIDTH-1:0] difficulty,
  input  logic                       speed,
  input  logic                       mode,
  input  logic                       settings_wr,
  input  logic                       player_wr,
  input  logic                       mem_wr,
  input  logic                       mem_rd,
  input  logic                       inc_match_index,
  input  logic                       inc_sequence_index,
  input  logic                       rst_match,
  input  logic                       rst_sequence,
  input  logic                       enable_led,
  input  logic                       update_score,
  output logic [DATA_WIDTH-1:0]      sequence_item,
  output logic [ADDR_WIDTH-1:0]      match_index,
  output logic [ADDR_WIDTH-1:0]      sequence_index,
  output logic [ADDR_WIDTH-1:0]      difficulty_index,
  output logic [DATA_WIDTH-1:0]      player_item,
  output logic                       speed_q,
  output logic                       mode_q,
  output logic [DATA_WIDTH-1:0]      leds,
  output logic [SCORE_WIDTH-1:0]     score
);

  import typedefs_pkg::*;

  localparam logic [ADDR_WIDTH-1:0]  c_IDX_MAX   = '1;
  localparam logic [SCORE_WIDTH-1:0] c_SCORE_MAX = '1;

  logic [DATA_WIDTH-1:0]      r_mem [2**ADDR_WIDTH];
  logic [DIFICULTY_WIDTH-1:0] r_difficulty;
  logic [DATA_WIDTH-1:0]      w_new_item;
  logic [SCORE_WIDTH:0]       w_score_sum;

  sequence_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .item (w_new_item)
  );

  // Sequence memory: no reset on contents; writes are discarded during rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) begin
      r_mem[sequence_index] <= w_new_item;
    end
  end

  // Registered read; a same-address write in the same cycle forwards the new item.
  always_ff @(posedge clk) begin
    if (rst) begin
      sequence_item <= '0;
    end else if (mem_rd) begin
      if (mem_wr && (match_index == sequence_index)) begin
        sequence_item <= w_new_item;
      end else begin
        sequence_item <= r_mem[match_index];
      end
    end
  end

  // Match index: clear beats increment, increment saturates.
  always_ff @(posedge clk) begin
    if (rst || rst_match) begin
      match_index <= '0;
    end else if (inc_match_index && (match_index != c_IDX_MAX)) begin
      match_index <= match_index + 1'b1;
    end
  end

  // Sequence index: clear beats increment, increment saturates.
  always_ff @(posedge clk) begin
    if (rst || rst_sequence) begin
      sequence_index <= '0;
    end else if (inc_sequence_index && (sequence_index != c_IDX_MAX)) begin
      sequence_index <= sequence_index + 1'b1;
    end
  end

  // Game settings latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_difficulty <= '0;
      speed_q      <= 1'b0;
      mode_q       <= 1'b0;
    end else if (settings_wr) begin
      r_difficulty <= difficulty;
      speed_q      <= speed;
      mode_q       <= mode;
    end
  end

  // Target length decoded from the latched difficulty.
  always_comb begin
    difficulty_index = ADDR_WIDTH'(DIFF_LEN_0);
    case (r_difficulty)
      DIFICULTY_WIDTH'(1): difficulty_index = ADDR_WIDTH'(DIFF_LEN_1);
      DIFICULTY_WIDTH'(2): difficulty_index = ADDR_WIDTH'(DIFF_LEN_2);
      DIFICULTY_WIDTH'(3): difficulty_index = ADDR_WIDTH'(DIFF_LEN_3);
      default:             difficulty_index = ADDR_WIDTH'(DIFF_LEN_0);
    endcase
  end

  // Player input latch; an all-zero vector means no press and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      player_item <= '0;
    end else if (player_wr && (|player_input)) begin
      player_item <= player_input;
    end
  end

  // LED drive follows the registered item only while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '0;
    end else if (enable_led) begin
      leds <= sequence_item;
    end else begin
      leds <= '0;
    end
  end

  // One extra bit on the sum catches overflow for saturation.
  assign w_score_sum = {1'b0, score} + (SCORE_WIDTH+1)'(sequence_index);

  // Score accumulates the current sequence length, saturating at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      score <= '0;
    end else if (update_score) begin
      if (w_score_sum[SCORE_WIDTH]) begin
        score <= c_SCORE_MAX;
      end else begin
        score <= w_score_sum[SCORE_WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sequence_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_datapath
//  Description : Directed self-checking bench for sequence_datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sequence_datapath;

  logic       clk;
  logic       rst;
  logic [3:0] player_input;
  logic [1:0] difficulty;
  logic       speed, mode, settings_wr, player_wr, mem_wr, mem_rd;
  logic       inc_match_index, inc_sequence_index, rst_match, rst_sequence;
  logic       enable_led, update_score;
  logic [3:0] sequence_item, player_item, leds;
  logic [4:0] match_index, sequence_index, difficulty_index;
  logic       speed_q, mode_q;
  logic [7:0] score;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5, used to predict new items.
  logic [7:0] m_lfsr;

  sequence_datapath dut (
    .clk                (clk),
    .rst                (rst),
    .player_input       (player_input),
    .difficulty         (difficulty),
    .speed              (speed),
    .mode               (mode),
    .settings_wr        (settings_wr),
    .player_wr          (player_wr),
    .mem_wr             (mem_wr),
    .mem_rd             (mem_rd),
    .inc_match_index    (inc_match_index),
    .inc_sequence_index (inc_sequence_index),
    .rst_match          (rst_match),
    .rst_sequence       (rst_sequence),
    .enable_led         (enable_led),
    .update_score       (update_score),
    .sequence_item      (sequence_item),
    .match_index        (match_index),
    .sequence_index     (sequence_index),
    .difficulty_index   (difficulty_index),
    .player_item        (player_item),
    .speed_q            (speed_q),
    .mode_q             (mode_q),
    .leds               (leds),
    .score              (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR stepping alongside the design.
  always @(posedge clk) begin
    if (rst || m_lfsr == 8'h00) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_items [3];
  logic [3:0] exp_wf;
  logic [7:0] set_tbl [4];

  initial begin
    // Hand-derived: A5->item 0010, 4A->0100, 95->0010.
    exp_items[0] = 4'b0010;
    exp_items[1] = 4'b0100;
    exp_items[2] = 4'b0010;
    // {difficulty[1:0], speed, mode, expected index[3:0] unused} packed as d,s,m
    set_tbl[0] = {2'd2, 1'b1, 1'b1, 4'd0};
    set_tbl[1] = {2'd3, 1'b0, 1'b1, 4'd0};
    set_tbl[2] = {2'd1, 1'b1, 1'b0, 4'd0};
    set_tbl[3] = {2'd0, 1'b0, 1'b0, 4'd0};

    rst = 1'b1;
    player_input = '0; difficulty = '0; speed = 0; mode = 0;
    settings_wr = 0; player_wr = 0; mem_wr = 0; mem_rd = 0;
    inc_match_index = 0; inc_sequence_index = 0; rst_match = 0; rst_sequence = 0;
    enable_led = 0; update_score = 0;

    repeat (2) tick();
    rst = 1'b0;
    check_eq("rst_item",  sequence_item, 0);
    check_eq("rst_match", match_index, 0);
    check_eq("rst_seq",   sequence_index, 0);
    check_eq("rst_diff",  difficulty_index, 8);
    check_eq("rst_player", player_item, 0);
    check_eq("rst_speed", speed_q, 0);
    check_eq("rst_mode",  mode_q, 0);
    check_eq("rst_leds",  leds, 0);
    check_eq("rst_score", score, 0);

    // Three writes starting on the first cycle out of reset.
    mem_wr = 1; inc_sequence_index = 1;
    repeat (3) tick();
    mem_wr = 0; inc_sequence_index = 0;
    check_eq("seq_after_wr", sequence_index, 3);

    rst_match = 1; tick(); rst_match = 0;
    check_eq("match_cleared", match_index, 0);

    mem_rd = 1; inc_match_index = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("rd_item%0d", i), sequence_item, exp_items[i]);
      check_eq($sformatf("rd_onehot%0d", i), $onehot(sequence_item), 1);
    end
    mem_rd = 0; inc_match_index = 0;
    check_eq("match_after_rd", match_index, 3);
    tick();
    check_eq("item_hold", sequence_item, 4'b0010);

    // Read and write at the same address: new item is returned.
    exp_wf = 4'(1) << m_lfsr[1:0];
    mem_wr = 1; mem_rd = 1;
    tick();
    mem_wr = 0; mem_rd = 0;
    check_eq("write_first", sequence_item, exp_wf);

    enable_led = 1; tick();
    check_eq("leds_on", leds, exp_wf);
    enable_led = 0; tick();
    check_eq("leds_off", leds, 0);

    // Settings table.
    for (int i = 0; i < 4; i++) begin
      {difficulty, speed, mode} = set_tbl[i][7:4];
      settings_wr = 1; tick(); settings_wr = 0;
      check_eq($sformatf("diff_idx%0d", i), difficulty_index,
               (set_tbl[i][7:6] == 2'd0) ? 8 : (set_tbl[i][7:6] == 2'd1) ? 16 :
               (set_tbl[i][7:6] == 2'd2) ? 24 : 31);
      check_eq($sformatf("speed%0d", i), speed_q, set_tbl[i][5]);
      check_eq($sformatf("mode%0d", i), mode_q, set_tbl[i][4]);
    end
    difficulty = 2'd3; speed = 1; mode = 1; tick();
    check_eq("settings_hold", difficulty_index, 8);

    // Sequence index: clear beats increment, then saturation.
    inc_sequence_index = 1; repeat (2) tick(); inc_sequence_index = 0;
    check_eq("seq_at5", sequence_index, 5);
    rst_sequence = 1; inc_sequence_index = 1; tick(); rst_sequence = 0;
    check_eq("seq_clr_prio", sequence_index, 0);
    repeat (31) tick();
    check_eq("seq_31", sequence_index, 31);
    repeat (9) tick();
    inc_sequence_index = 0;
    check_eq("seq_sat", sequence_index, 31);

    // Player latch.
    player_input = 4'b0100; player_wr = 1; tick();
    check_eq("player_0100", player_item, 4'b0100);
    player_input = 4'b0000; tick();
    check_eq("player_zero_hold", player_item, 4'b0100);
    player_input = 4'b1011; tick(); player_wr = 0;
    check_eq("player_multi", player_item, 4'b1011);

    // Score saturation with sequence_index = 31.
    update_score = 1;
    repeat (8) tick();
    check_eq("score_248", score, 248);
    tick();
    check_eq("score_sat", score, 255);
    tick();
    check_eq("score_sat_hold", score, 255);

    // Reset during strobes discards them.
    rst = 1; inc_match_index = 1; player_input = 4'b0001; player_wr = 1;
    tick();
    check_eq("midrst_score", score, 0);
    check_eq("midrst_match", match_index, 0);
    check_eq("midrst_player", player_item, 0);
    check_eq("midrst_seq", sequence_index, 0);
    check_eq("midrst_diff", difficulty_index, 8);
    rst = 0; update_score = 0; inc_match_index = 0; player_wr = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
